// File: rtl/vga_sync_pkg.sv
// Shared display timing for the 800x600 @ 72 Hz raster (50 MHz pixel rate).
package vga_sync_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FP      = 56;
  localparam int H_SYNC    = 120;
  localparam int H_BP      = 64;
  localparam int H_TOTAL   = 1040;
  localparam int V_VISIBLE = 600;
  localparam int V_FP      = 37;
  localparam int V_SYNC    = 6;
  localparam int V_BP      = 23;
  localparam int V_TOTAL   = 666;
  localparam int COORD_W   = 12;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_sync.sv
// Raster timing generator: pixel-enable divider, h/v counters and registered sync/visible flags.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int H_ACTIVE = H_VISIBLE,
  parameter int H_FRONT  = H_FP,
  parameter int H_PULSE  = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACTIVE = V_VISIBLE,
  parameter int V_FRONT  = V_FP,
  parameter int V_PULSE  = V_SYNC,
  parameter int V_BACK   = V_BP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [COORD_W-1:0] x_p,
  output logic [COORD_W-1:0] y_p,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam coord_t ONE      = coord_t'(1);
  localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FRONT + H_PULSE + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FRONT + V_PULSE + V_BACK - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FRONT + H_PULSE - 1);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FRONT + V_PULSE - 1);

  logic   tog;
  coord_t h_cnt, v_cnt;
  coord_t h_nxt, v_nxt;
  logic   h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + ONE;
      end else begin
        h_nxt = h_cnt + ONE;
      end
    end
  end

  // Flags are computed from the next count so they land on the same edge as x_p/y_p.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog        <= 1'b0;
      pix_en     <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      visible    <= 1'b1;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      tog        <= ~tog;
      pix_en     <= tog;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      visible    <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
      hsync      <= in_window(h_nxt, HS_START, HS_END);
      vsync      <= in_window(v_nxt, VS_START, VS_END);
      frame_tick <= pix_en && h_wrap && v_wrap;
    end
  end

  assign x_p = h_cnt;
  assign y_p = v_cnt;

endmodule
